// File: rtl/axis_crc24_check.sv
// Purpose: strips and checks a trailing 3-byte CRC-24 on an AXI-Stream byte frame, forwarding only payload.
// Latency: a payload byte appears 1 cycle after the 3rd byte that follows it is accepted.
// Backpressure: s_tready = m_tready || !m_tvalid; the single-entry output register is never overwritten while stalled.
module axis_crc24_check #(
    parameter logic [23:0] POLY     = 24'h864CFB,
    parameter logic [23:0] CRC_INIT = 24'h000000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    output logic             m_tuser,
    input  logic             m_tready,
    output logic             frame_done,
    output logic             crc_ok,
    output logic             runt,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // One byte of CRC-24, MSB first, non-reflected.
    function automatic logic [23:0] crc_byte(input logic [23:0] crc_in, input logic [7:0] byte_in);
        logic [23:0] r;
        r = crc_in ^ {byte_in, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            r = r[23] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    // Running CRC and the 3-byte hold buffer; hold_q[0] is the oldest byte.
    logic [23:0]      crc_q,  crc_d;
    logic [1:0]       cnt_q,  cnt_d;
    logic [2:0][7:0]  hold_q, hold_d;

    // Output register.
    logic [7:0]       m_tdata_q,  m_tdata_d;
    logic             m_tvalid_q, m_tvalid_d;
    logic             m_tlast_q,  m_tlast_d;
    logic             m_tuser_q,  m_tuser_d;

    // Frame status and counters.
    logic             frame_done_q, frame_done_d;
    logic             crc_ok_q,     crc_ok_d;
    logic             runt_q,       runt_d;
    logic [CNT_W-1:0] good_cnt_q,   good_cnt_d;
    logic [CNT_W-1:0] bad_cnt_q,    bad_cnt_d;

    logic             accept;
    logic [23:0]      crc_next;
    logic             residue_bad;
    logic             buf_full;

    assign s_tready    = m_tready || !m_tvalid_q;
    assign accept      = s_tvalid && s_tready;
    assign crc_next    = crc_byte(crc_q, s_tdata);
    assign residue_bad = (crc_next != 24'h000000);
    assign buf_full    = (cnt_q == 2'd3);

    // Datapath next state: CRC update, hold buffer push/shift, output register load/drain.
    always_comb begin
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;

        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end

        if (accept) begin
            // A new frame always starts from CRC_INIT, so the reload happens on tlast.
            crc_d = s_tlast ? CRC_INIT : crc_next;

            if (buf_full) begin
                // Oldest byte is now known to be payload; the new byte takes the youngest slot.
                m_tvalid_d = 1'b1;
                m_tdata_d  = hold_q[0];
                m_tlast_d  = s_tlast;
                m_tuser_d  = s_tlast && residue_bad;
                hold_d     = {s_tdata, hold_q[2], hold_q[1]};
                cnt_d      = s_tlast ? 2'd0 : 2'd3;
            end else begin
                case (cnt_q)
                    2'd0:    hold_d[0] = s_tdata;
                    2'd1:    hold_d[1] = s_tdata;
                    default: hold_d[2] = s_tdata;
                endcase
                // A tlast here means a runt: drop everything buffered.
                cnt_d = s_tlast ? 2'd0 : cnt_q + 2'd1;
            end
        end
    end

    // Status next state: one-cycle frame-end pulses and saturating good/bad counters.
    always_comb begin
        frame_done_d = accept && s_tlast;
        crc_ok_d     = frame_done_d && buf_full && !residue_bad;
        runt_d       = frame_done_d && !buf_full;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;

        if (frame_done_d) begin
            if (crc_ok_d) begin
                if (good_cnt_q != CNT_MAX) begin
                    good_cnt_d = good_cnt_q + CNT_W'(1);
                end
            end else begin
                if (bad_cnt_q != CNT_MAX) begin
                    bad_cnt_d = bad_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q      <= CRC_INIT;
            cnt_q      <= 2'd0;
            hold_q     <= '0;
            m_tdata_q  <= 8'h00;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
        end else begin
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done_q <= 1'b0;
            crc_ok_q     <= 1'b0;
            runt_q       <= 1'b0;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
        end else begin
            frame_done_q <= frame_done_d;
            crc_ok_q     <= crc_ok_d;
            runt_q       <= runt_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

    assign m_tdata    = m_tdata_q;
    assign m_tvalid   = m_tvalid_q;
    assign m_tlast    = m_tlast_q;
    assign m_tuser    = m_tuser_q;
    assign frame_done = frame_done_q;
    assign crc_ok     = crc_ok_q;
    assign runt       = runt_q;
    assign good_cnt   = good_cnt_q;
    assign bad_cnt    = bad_cnt_q;

endmodule

// File: tb/tb_axis_crc24_check.sv
// Bench for axis_crc24_check: scoreboard of expected payload beats and frame status,
// with one task per scenario; counters built narrow so saturation is reachable.
module tb_axis_crc24_check;

    localparam int CW      = 3;
    localparam int CNT_TOP = (1 << CW) - 1;
    localparam logic [23:0] POLY = 24'h864CFB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    s_tdata = 8'h00;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [7:0]    m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tuser;
    logic          m_tready = 1'b1;
    logic          frame_done;
    logic          crc_ok;
    logic          runt;
    logic [CW-1:0] good_cnt;
    logic [CW-1:0] bad_cnt;

    axis_crc24_check #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .m_tready   (m_tready),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .runt       (runt),
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    beat_t      exp_q[$];
    logic [1:0] st_q[$];      // {crc_ok, runt}
    logic [7:0] fb[$];        // frame being built
    int         checks = 0;
    int         fails  = 0;
    int         model_good = 0;
    int         model_bad  = 0;
    int         stalls = 0;

    // Bit-serial reference CRC: returns the 3 check bytes for a payload.
    function automatic logic [23:0] ref_crc(input logic [7:0] p[$]);
        logic [23:0] c;
        logic        f;
        c = 24'h0;
        foreach (p[k]) begin
            for (int b = 7; b >= 0; b--) begin
                f = c[23] ^ p[k][b];
                c = {c[22:0], 1'b0};
                if (f) c = c ^ POLY;
            end
        end
        return c;
    endfunction

    // Output monitor: scoreboard pops, stall stability, status pulses.
    beat_t held;
    logic  held_vld = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            held_vld <= 1'b0;
        end else begin
            if (held_vld) begin
                checks++;
                if (!m_tvalid || {m_tdata, m_tlast, m_tuser} !== held) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%0b %h/%0b/%0b want v=1 %h/%0b/%0b",
                             m_tvalid, m_tdata, m_tlast, m_tuser, held.d, held.l, held.u);
                end
            end
            if (m_tvalid && !m_tready) begin
                held     <= beat_t'{d: m_tdata, l: m_tlast, u: m_tuser};
                held_vld <= 1'b1;
            end else begin
                held_vld <= 1'b0;
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got %h last=%0b want none", m_tdata, m_tlast);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (m_tdata !== e.d || m_tlast !== e.l || (e.l && m_tuser !== e.u)) begin
                        fails++;
                        $display("FAIL beat: got %h/%0b/%0b want %h/%0b/%0b",
                                 m_tdata, m_tlast, m_tuser, e.d, e.l, e.u);
                    end
                end
            end
            if (frame_done) begin
                checks++;
                if (st_q.size() == 0) begin
                    fails++;
                    $display("FAIL status_unexpected: got ok=%0b runt=%0b want none", crc_ok, runt);
                end else begin
                    logic [1:0] s;
                    s = st_q.pop_front();
                    if ({crc_ok, runt} !== s) begin
                        fails++;
                        $display("FAIL status: got ok=%0b runt=%0b want ok=%0b runt=%0b",
                                 crc_ok, runt, s[1], s[0]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            stalls++;
            n++;
            if (n > 200) begin
                checks++;
                fails++;
                $display("FAIL send_timeout: got s_tready=0 want 1 within 200 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Pushes expectations for fb (exp_bad = expected CRC mismatch), then drives it.
    task automatic send_frame(input logic exp_bad, input bit keep);
        int n;
        n = fb.size();
        if (n < 4) begin
            st_q.push_back(2'b01);
            if (model_bad < CNT_TOP) model_bad++;
        end else begin
            for (int i = 0; i < n - 3; i++)
                exp_q.push_back(beat_t'{d: fb[i], l: (i == n - 4), u: (i == n - 4) ? exp_bad : 1'b0});
            st_q.push_back({!exp_bad, 1'b0});
            if (!exp_bad && model_good < CNT_TOP) model_good++;
            if (exp_bad && model_bad < CNT_TOP) model_bad++;
        end
        for (int i = 0; i < n; i++) send_byte(fb[i], i == n - 1);
        if (!keep) begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    task automatic frame4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        fb = {a, b, c, d};
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        st_q.delete();
        model_good = 0;
        model_bad  = 0;
        reset_n = 1'b1;
    endtask

    task automatic drain_check(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || st_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || st_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: got %0d beats %0d status pending want 0", name, exp_q.size(), st_q.size());
        end
        checks++;
        if (good_cnt !== CW'(model_good)) begin
            fails++;
            $display("FAIL %s_good_cnt: got %0d want %0d", name, good_cnt, model_good);
        end
        checks++;
        if (bad_cnt !== CW'(model_bad)) begin
            fails++;
            $display("FAIL %s_bad_cnt: got %0d want %0d", name, bad_cnt, model_bad);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({m_tvalid, m_tlast, m_tuser, m_tdata, frame_done, crc_ok, runt} !== 14'h0 ||
            good_cnt !== '0 || bad_cnt !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%0b d=%h fd=%0b g=%0d b=%0d want all 0",
                     m_tvalid, m_tdata, frame_done, good_cnt, bad_cnt);
        end
        do_reset();
    endtask

    task automatic test_good_frame();
        do_reset();
        frame4(8'h01, 8'h86, 8'h4C, 8'hFB);
        send_frame(1'b0, 1'b0);
        drain_check("good");
    endtask

    task automatic test_bad_frame();
        do_reset();
        frame4(8'h01, 8'h86, 8'h4C, 8'hFA);
        send_frame(1'b1, 1'b0);
        drain_check("bad");
    endtask

    task automatic test_back_to_back();
        do_reset();
        stalls = 0;
        frame4(8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(1'b0, 1'b1);
        frame4(8'h01, 8'h86, 8'h4C, 8'hFB);
        send_frame(1'b0, 1'b0);
        checks++;
        if (stalls != 0) begin
            fails++;
            $display("FAIL b2b_stalls: got %0d want 0", stalls);
        end
        drain_check("b2b");
    endtask

    task automatic test_runt();
        do_reset();
        fb = {8'h86, 8'h4C, 8'hFB};
        send_frame(1'b0, 1'b0);
        frame4(8'h01, 8'h86, 8'h4C, 8'hFB);
        send_frame(1'b0, 1'b0);
        drain_check("runt");
    endtask

    task automatic test_backpressure();
        do_reset();
        m_tready = 1'b0;
        fork
            begin
                frame4(8'h01, 8'h86, 8'h4C, 8'hFB);
                send_frame(1'b0, 1'b0);
                frame4(8'h00, 8'h00, 8'h00, 8'h00);
                send_frame(1'b0, 1'b0);
            end
            begin
                repeat (12) @(posedge clk);
                @(negedge clk);
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== 8'h01 || s_tready !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_stall: got v=%0b d=%h rdy=%0b want v=1 d=01 rdy=0",
                             m_tvalid, m_tdata, s_tready);
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain_check("bp");
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h86, 1'b0);
        s_tvalid = 1'b0;
        reset_n  = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || frame_done !== 1'b0 || good_cnt !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got v=%0b fd=%0b g=%0d want 0", m_tvalid, frame_done, good_cnt);
        end
        do_reset();
        frame4(8'h01, 8'h86, 8'h4C, 8'hFB);
        send_frame(1'b0, 1'b0);
        drain_check("midreset");
    endtask

    task automatic test_random_frames();
        logic [23:0] c;
        int n;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(12, 5);
            fb.delete();
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(255, 0)));
            c = ref_crc(fb);
            fb.push_back(c[23:16]);
            fb.push_back(c[15:8]);
            fb.push_back(c[7:0]);
            send_frame(1'b0, 1'b1);
            fb[1] = fb[1] ^ 8'h10;
            send_frame(1'b1, 1'b0);
        end
        drain_check("random");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int r = 0; r < CNT_TOP + 2; r++) begin
            frame4(8'h00, 8'h00, 8'h00, 8'h00);
            send_frame(1'b0, 1'b1);
            fb.delete();
            for (int i = 0; i <= r % 3; i++) fb.push_back(8'h5A);
            send_frame(1'b0, 1'b0);
        end
        drain_check("sat");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_back_to_back();
        test_runt();
        test_backpressure();
        test_reset_mid_frame();
        test_random_frames();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
